uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   UART 8N1 receiver: mirror of the board's UART transmit path. Samples the
//   serial line at mid-bit, assembles bytes (LSB first) and hands each byte to
//   downstream logic (VGA text/pixel writer) through a valid/ready register.
//   Flags framing errors and overruns.
// PARAMETERS
//   CLK_HZ        100_000_000  system clock frequency (Hz)
//   BAUD          9600         line rate (bit/s)
//   CLKS_PER_BIT  CLK_HZ/BAUD  derived local param, 10416 at defaults; counter width $clog2(CLKS_PER_BIT)
// PORTS
//   clk         in   1  system clock, all logic on rising edge
//   reset_p     in   1  asynchronous, active-high reset
//   rx          in   1  serial line, idle high, asynchronous to clk
//   data_out    out  8  received byte, stable while data_valid=1
//   data_valid  out  1  byte available; held until accepted
//   data_ready  in   1  consumer accepts byte when data_valid & data_ready
//   rx_busy     out  1  high in any state other than IDLE
//   frame_err   out  1  one-cycle pulse: stop bit sampled low
//   overrun     out  1  one-cycle pulse: new byte completed while previous unaccepted
// BEHAVIOUR
//   Reset: state=IDLE, counters=0, data_out=8'h00, data_valid=0, rx_busy=0,
//     frame_err=0, overrun=0, synchronizer flops=1 (line idle).
//   rx passes a 2-flop synchronizer (rx_s); rx_s_d = rx_s delayed 1 cycle.
//   FSM (baud counter cnt, bit index idx 0..7, shift reg sr):
//   - IDLE: on rx_s_d=1 & rx_s=0 (falling edge) -> START, cnt=0.
//   - START: count to CLKS_PER_BIT/2-1 (mid start bit); rx_s=0 -> DATA, cnt=0,
//     idx=0; rx_s=1 -> IDLE (glitch rejected, no flags).
//   - DATA: at cnt=CLKS_PER_BIT-1 sample rx_s into sr[idx], cnt=0; after
//     idx=7 -> STOP, else idx+1.
//   - STOP: at cnt=CLKS_PER_BIT-1 sample rx_s; -> IDLE same cycle (ready for a
//     new start edge during the second half of the stop bit).
//     rx_s=1: byte complete. rx_s=0: frame_err pulse next cycle, byte
//     discarded, data_out/data_valid unchanged.
//   Byte complete (registered, effective next cycle):
//   - data_valid=0, or data_valid=1 & data_ready=1 same cycle: data_out<=sr,
//     data_valid<=1, no overrun.
//   - data_valid=1 & data_ready=0: data_out<=sr (newest wins), data_valid stays
//     1, overrun pulses 1 cycle.
//   Accept without completion: data_valid<=0 next cycle; data_out holds value.
//   data_ready while data_valid=0: ignored.
//   Latency: rx edge -> sample in synchronizer 2 cycles; stop-bit mid-sample ->
//     data_valid high 1 cycle later.
//   Counters never wrap: cnt clears on every sample point or state change.
//   reset_p mid-frame: immediate return to reset values; partial byte lost;
//     reception resumes on next falling edge after release.
// TESTING (bench with CLK_HZ=16, BAUD=1 -> CLKS_PER_BIT=16)
//   1 Send 8'hA5 (start, 1,0,1,0,0,1,0,1, stop), data_ready=1 -> data_valid
//     1 cycle, data_out=8'hA5, frame_err=0, rx_busy high ~10 bit times.
//   2 Send 8'h3C with stop bit driven 0 -> frame_err pulse once, data_valid
//     stays 0, data_out keeps prior value; next frame 8'h55 received cleanly.
//   3 rx low pulse of 4 cycles in IDLE -> returns to IDLE at mid-start, no
//     data_valid, no frame_err.
//   4 data_ready=0, send 8'h11 then 8'h22 back-to-back -> after 2nd stop:
//     data_out=8'h22, data_valid=1, overrun one pulse; raise data_ready ->
//     data_valid low next cycle.
//   5 data_ready asserted exactly on cycle byte 8'h77 completes with 8'h66
//     pending -> data_out=8'h77, data_valid stays 1, overrun=0.
//   6 Assert reset_p during bit 4 of 8'hF0 -> all outputs reset values
//     immediately; following frame 8'h0F received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART 8N1 receiver: mid-bit sampling, LSB-first byte assembly, valid/ready output register.
// Latency: rx edge to synchronizer output 2 cycles; stop-bit sample to data_valid 1 cycle.
// Backpressure: an unaccepted byte is overwritten by the next one (newest wins) with an overrun pulse.
module uart_rx #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    // Full bit period and half bit period terminal counts
    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    sr;
    logic          rx_m;
    logic          rx_s;
    logic          rx_s_d;

    // Two-flop synchronizer plus one delay stage for falling-edge detection; resets to idle-high
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            rx_m   <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_d <= 1'b1;
        end else begin
            rx_m   <= rx;
            rx_s   <= rx_m;
            rx_s_d <= rx_s;
        end
    end

    // Receive FSM with registered handshake, busy and error outputs
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= 3'd0;
            sr         <= 8'h00;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            rx_busy    <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            // Plain accept; a byte completing this same cycle overrides it below
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (rx_s_d && !rx_s) begin
                        state   <= START;
                        cnt     <= '0;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        idx <= 3'd0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            // Line back high at mid start bit: treat as a glitch
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_BIT) begin
                        cnt     <= '0;
                        sr[idx] <= rx_s;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_BIT) begin
                        // Back to IDLE at mid stop bit so a following start edge is not missed
                        cnt     <= '0;
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                        if (rx_s) begin
                            data_out   <= sr;
                            data_valid <= 1'b1;
                            if (data_valid && !data_ready) begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
// Frames are driven bit-by-bit; a negedge monitor counts handshake and error events.
// Each scenario task compares observed events against hand-derived values.
module tb_uart_rx;

    logic       clk;
    logic       reset_p;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int vec  = 0;
    int errs = 0;

    // Event monitor state
    int         cyc        = 0;
    int         dv_rises   = 0;
    int         dv_falls   = 0;
    int         dv_hi      = 0;
    int         dv_rise_cyc = 0;
    logic [7:0] dv_rise_dat = 8'h00;
    int         fe_cnt     = 0;
    int         fe_cyc     = 0;
    int         ov_cnt     = 0;
    int         ov_cyc     = 0;
    int         busy_cnt   = 0;
    logic       dv_q       = 1'b0;
    int         frame_start = 0;

    uart_rx #(.CLK_HZ(16), .BAUD(1)) dut (
        .clk        (clk),
        .reset_p    (reset_p),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count output events away from the active edge
    always @(negedge clk) begin
        if (data_valid && !dv_q) begin
            dv_rises    <= dv_rises + 1;
            dv_rise_cyc <= cyc;
            dv_rise_dat <= data_out;
        end
        if (!data_valid && dv_q) dv_falls <= dv_falls + 1;
        if (data_valid) dv_hi <= dv_hi + 1;
        if (frame_err) begin
            fe_cnt <= fe_cnt + 1;
            fe_cyc <= cyc;
        end
        if (overrun) begin
            ov_cnt <= ov_cnt + 1;
            ov_cyc <= cyc;
        end
        if (rx_busy) busy_cnt <= busy_cnt + 1;
        dv_q <= data_valid;
    end

    // Called 1 time unit after a posedge; returns in the same phase 160 cycles later
    task automatic send(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        frame_start = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (16) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_p    = 1'b1;
        rx         = 1'b1;
        data_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vec++; if (data_out !== 8'h00) begin errs++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
        vec++; if (data_valid !== 1'b0) begin errs++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
        vec++; if (rx_busy !== 1'b0) begin errs++; $display("FAIL reset_rx_busy got=%b exp=0", rx_busy); end
        vec++; if (frame_err !== 1'b0) begin errs++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        vec++; if (overrun !== 1'b0) begin errs++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        reset_p = 1'b0;
        idle(4);
    endtask

    task automatic test_basic_rx;
        int r0, h0, f0, b0;
        data_ready = 1'b1;
        r0 = dv_rises; h0 = dv_hi; f0 = fe_cnt; b0 = busy_cnt;
        send(8'hA5, 1'b1);
        idle(4);
        vec++; if (dv_rises - r0 !== 1) begin errs++; $display("FAIL basic_dv_rises got=%0d exp=1", dv_rises - r0); end
        vec++; if (dv_hi - h0 !== 1) begin errs++; $display("FAIL basic_dv_width got=%0d exp=1", dv_hi - h0); end
        vec++; if (dv_rise_dat !== 8'hA5) begin errs++; $display("FAIL basic_data got=%h exp=a5", dv_rise_dat); end
        vec++; if (dv_rise_cyc - frame_start !== 155) begin errs++; $display("FAIL basic_latency got=%0d exp=155", dv_rise_cyc - frame_start); end
        vec++; if (fe_cnt - f0 !== 0) begin errs++; $display("FAIL basic_frame_err got=%0d exp=0", fe_cnt - f0); end
        vec++; if (busy_cnt - b0 !== 152) begin errs++; $display("FAIL basic_busy_cycles got=%0d exp=152", busy_cnt - b0); end
    endtask

    task automatic test_frame_err;
        int r0, f0;
        data_ready = 1'b1;
        r0 = dv_rises; f0 = fe_cnt;
        send(8'h3C, 1'b0);
        idle(4);
        vec++; if (fe_cnt - f0 !== 1) begin errs++; $display("FAIL ferr_pulses got=%0d exp=1", fe_cnt - f0); end
        vec++; if (fe_cyc - frame_start !== 155) begin errs++; $display("FAIL ferr_timing got=%0d exp=155", fe_cyc - frame_start); end
        vec++; if (dv_rises - r0 !== 0) begin errs++; $display("FAIL ferr_dv_rises got=%0d exp=0", dv_rises - r0); end
        vec++; if (data_out !== 8'hA5) begin errs++; $display("FAIL ferr_data_held got=%h exp=a5", data_out); end
        r0 = dv_rises; f0 = fe_cnt;
        send(8'h55, 1'b1);
        idle(4);
        vec++; if (dv_rises - r0 !== 1) begin errs++; $display("FAIL ferr_next_dv got=%0d exp=1", dv_rises - r0); end
        vec++; if (dv_rise_dat !== 8'h55) begin errs++; $display("FAIL ferr_next_data got=%h exp=55", dv_rise_dat); end
        vec++; if (fe_cnt - f0 !== 0) begin errs++; $display("FAIL ferr_next_clean got=%0d exp=0", fe_cnt - f0); end
    endtask

    task automatic test_glitch;
        int r0, f0, b0;
        r0 = dv_rises; f0 = fe_cnt; b0 = busy_cnt;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        idle(40);
        vec++; if (dv_rises - r0 !== 0) begin errs++; $display("FAIL glitch_dv got=%0d exp=0", dv_rises - r0); end
        vec++; if (fe_cnt - f0 !== 0) begin errs++; $display("FAIL glitch_frame_err got=%0d exp=0", fe_cnt - f0); end
        vec++; if (busy_cnt - b0 !== 8) begin errs++; $display("FAIL glitch_busy_cycles got=%0d exp=8", busy_cnt - b0); end
        vec++; if (rx_busy !== 1'b0) begin errs++; $display("FAIL glitch_idle got=%b exp=0", rx_busy); end
    endtask

    task automatic test_back_to_back;
        int o0;
        data_ready = 1'b0;
        o0 = ov_cnt;
        send(8'h11, 1'b1);
        vec++; if (data_out !== 8'h11 || data_valid !== 1'b1) begin errs++; $display("FAIL b2b_first got=%h/%b exp=11/1", data_out, data_valid); end
        send(8'h22, 1'b1);
        idle(2);
        vec++; if (data_out !== 8'h22) begin errs++; $display("FAIL b2b_newest got=%h exp=22", data_out); end
        vec++; if (data_valid !== 1'b1) begin errs++; $display("FAIL b2b_valid got=%b exp=1", data_valid); end
        vec++; if (ov_cnt - o0 !== 1) begin errs++; $display("FAIL b2b_overrun got=%0d exp=1", ov_cnt - o0); end
        vec++; if (ov_cyc - frame_start !== 155) begin errs++; $display("FAIL b2b_overrun_timing got=%0d exp=155", ov_cyc - frame_start); end
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        vec++; if (data_valid !== 1'b0) begin errs++; $display("FAIL b2b_accept got=%b exp=0", data_valid); end
        vec++; if (data_out !== 8'h22) begin errs++; $display("FAIL b2b_hold got=%h exp=22", data_out); end
        data_ready = 1'b0;
        idle(4);
    endtask

    task automatic test_accept_on_complete;
        int o0, fl0;
        data_ready = 1'b0;
        send(8'h66, 1'b1);
        o0 = ov_cnt; fl0 = dv_falls;
        fork
            send(8'h77, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1;
                data_ready = 1'b1;
                @(posedge clk);
                #1;
                data_ready = 1'b0;
            end
        join
        vec++; if (data_out !== 8'h77) begin errs++; $display("FAIL acc_data got=%h exp=77", data_out); end
        vec++; if (data_valid !== 1'b1) begin errs++; $display("FAIL acc_valid got=%b exp=1", data_valid); end
        vec++; if (ov_cnt - o0 !== 0) begin errs++; $display("FAIL acc_overrun got=%0d exp=0", ov_cnt - o0); end
        vec++; if (dv_falls - fl0 !== 0) begin errs++; $display("FAIL acc_dv_drop got=%0d exp=0", dv_falls - fl0); end
    endtask

    task automatic test_mid_frame_reset;
        int r0;
        r0 = dv_rises;
        fork
            send(8'hF0, 1'b1);
            begin
                repeat (85) @(posedge clk);
                #1;
                reset_p = 1'b1;
                #1;
                vec++; if (data_out !== 8'h00) begin errs++; $display("FAIL rst_mid_data got=%h exp=00", data_out); end
                vec++; if (data_valid !== 1'b0) begin errs++; $display("FAIL rst_mid_valid got=%b exp=0", data_valid); end
                vec++; if (rx_busy !== 1'b0) begin errs++; $display("FAIL rst_mid_busy got=%b exp=0", rx_busy); end
                repeat (3) @(posedge clk);
                #1;
                reset_p = 1'b0;
            end
        join
        idle(4);
        vec++; if (dv_rises - r0 !== 0) begin errs++; $display("FAIL rst_partial_lost got=%0d exp=0", dv_rises - r0); end
        vec++; if (rx_busy !== 1'b0) begin errs++; $display("FAIL rst_idle got=%b exp=0", rx_busy); end
        data_ready = 1'b1;
        r0 = dv_rises;
        send(8'h0F, 1'b1);
        idle(4);
        vec++; if (dv_rises - r0 !== 1) begin errs++; $display("FAIL rst_resume_dv got=%0d exp=1", dv_rises - r0); end
        vec++; if (dv_rise_dat !== 8'h0F) begin errs++; $display("FAIL rst_resume_data got=%h exp=0f", dv_rise_dat); end
    endtask

    initial begin
        test_reset();
        test_basic_rx();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_accept_on_complete();
        test_mid_frame_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
